router1x3_fsm: RTL and testbench

Control state machine for the 1x3 packet router. It watches the input packet stream and decides when to decode the header address, load header and payload bytes, stall on a full destination FIFO, and load and check parity. It sits between the router input and the register, synchronizer and FIFO blocks, and drives their control strobes and the `busy` back-pressure to the source.

---
 rtl/router_pkg.sv | 23 ++
 rtl/router1x3_fsm.sv | 120 ++++++++++++
 tb/tb_router1x3_fsm.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: control FSM state encoding and header address constants.
package router_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned ADDR_W  = 2;

   typedef enum logic [STATE_W-1:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR0        = 2'b00;
   localparam logic [ADDR_W-1:0] ADDR1        = 2'b01;
   localparam logic [ADDR_W-1:0] ADDR2        = 2'b10;
   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router1x3_fsm.sv
// Control FSM of the 1x3 packet router.
// Inputs : clock, reset (sync, active-high), pkt_valid, parity_done, data_in[1:0],
//          soft_reset_0..2, fifo_full, low_pkt_valid, fifo_empty_0..2
// Outputs: detect_add, ld_state, laf_state, full_state, write_enb_reg,
//          rst_int_reg, lfd_state, busy (all registered, Moore on state)
module router1x3_fsm
   import router_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              pkt_valid,
   input  logic              parity_done,
   input  logic [ADDR_W-1:0] data_in,
   input  logic              soft_reset_0,
   input  logic              soft_reset_1,
   input  logic              soft_reset_2,
   input  logic              fifo_full,
   input  logic              low_pkt_valid,
   input  logic              fifo_empty_0,
   input  logic              fifo_empty_1,
   input  logic              fifo_empty_2,
   output logic              detect_add,
   output logic              ld_state,
   output logic              laf_state,
   output logic              full_state,
   output logic              write_enb_reg,
   output logic              rst_int_reg,
   output logic              lfd_state,
   output logic              busy
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;

   // Padded to 4 bits so the invalid address indexes a constant 0.
   logic [3:0] empty_v, soft_v;
   logic       hdr_ok, empty_hdr, empty_addr, soft_hit;

   logic detect_add_nxt, ld_state_nxt, laf_state_nxt, full_state_nxt;
   logic write_enb_reg_nxt, rst_int_reg_nxt, lfd_state_nxt, busy_nxt;

   assign empty_v    = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign soft_v     = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
   assign hdr_ok     = pkt_valid && (data_in != ADDR_INVALID);
   assign empty_hdr  = empty_v[data_in];
   assign empty_addr = empty_v[addr];
   assign soft_hit   = soft_v[addr];

   // State, address and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= DECODE_ADDRESS;
         addr          <= ADDR0;
         detect_add    <= 1'b1;
         ld_state      <= 1'b0;
         laf_state     <= 1'b0;
         full_state    <= 1'b0;
         write_enb_reg <= 1'b0;
         rst_int_reg   <= 1'b0;
         lfd_state     <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_nxt;
         addr          <= addr_nxt;
         detect_add    <= detect_add_nxt;
         ld_state      <= ld_state_nxt;
         laf_state     <= laf_state_nxt;
         full_state    <= full_state_nxt;
         write_enb_reg <= write_enb_reg_nxt;
         rst_int_reg   <= rst_int_reg_nxt;
         lfd_state     <= lfd_state_nxt;
         busy          <= busy_nxt;
      end
   end

   // Next-state logic; outputs decoded from the next state so they register
   // into alignment with the state they describe.
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;

      case (state)
         DECODE_ADDRESS: begin
            if (hdr_ok) begin
               addr_nxt  = data_in;
               state_nxt = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
         end
         WAIT_TILL_EMPTY:    if (empty_addr) state_nxt = LOAD_FIRST_DATA;
         LOAD_FIRST_DATA:    state_nxt = LOAD_DATA;
         LOAD_DATA: begin
            if (fifo_full)       state_nxt = FIFO_FULL_STATE;
            else if (!pkt_valid) state_nxt = LOAD_PARITY;
         end
         FIFO_FULL_STATE:    if (!fifo_full) state_nxt = LOAD_AFTER_FULL;
         LOAD_AFTER_FULL: begin
            if (parity_done)        state_nxt = DECODE_ADDRESS;
            else if (low_pkt_valid) state_nxt = LOAD_PARITY;
            else                    state_nxt = LOAD_DATA;
         end
         LOAD_PARITY:        state_nxt = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         default:            state_nxt = DECODE_ADDRESS;
      endcase

      // Timeout on the active port aborts the packet from any non-idle state.
      if (state != DECODE_ADDRESS && soft_hit) state_nxt = DECODE_ADDRESS;

      detect_add_nxt    = (state_nxt == DECODE_ADDRESS);
      lfd_state_nxt     = (state_nxt == LOAD_FIRST_DATA);
      ld_state_nxt      = (state_nxt == LOAD_DATA);
      laf_state_nxt     = (state_nxt == LOAD_AFTER_FULL);
      full_state_nxt    = (state_nxt == FIFO_FULL_STATE);
      rst_int_reg_nxt   = (state_nxt == CHECK_PARITY_ERROR);
      write_enb_reg_nxt = (state_nxt == LOAD_DATA) || (state_nxt == LOAD_PARITY) ||
                          (state_nxt == LOAD_AFTER_FULL);
      busy_nxt          = !((state_nxt == DECODE_ADDRESS) || (state_nxt == LOAD_DATA));
   end

endmodule

// File: tb/tb_router1x3_fsm.sv
// Testbench for router1x3_fsm: directed vector table plus randomized run against a reference model.
module tb_router1x3_fsm;

   logic       clock = 1'b0;
   logic       reset, pkt_valid, parity_done, fifo_full, low_pkt_valid;
   logic [1:0] data_in;
   logic [2:0] sr, emp;
   logic detect_add, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, lfd_state, busy;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   router1x3_fsm dut (
      .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .parity_done(parity_done),
      .data_in(data_in), .soft_reset_0(sr[0]), .soft_reset_1(sr[1]), .soft_reset_2(sr[2]),
      .fifo_full(fifo_full), .low_pkt_valid(low_pkt_valid),
      .fifo_empty_0(emp[0]), .fifo_empty_1(emp[1]), .fifo_empty_2(emp[2]),
      .detect_add(detect_add), .ld_state(ld_state), .laf_state(laf_state),
      .full_state(full_state), .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg),
      .lfd_state(lfd_state), .busy(busy));

   // Output vector order: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
   localparam logic [7:0] O_DEC  = 8'h80, O_LFD  = 8'h41, O_LD   = 8'h24, O_LAF = 8'h15,
                          O_FULL = 8'h09, O_LP   = 8'h05, O_CHK  = 8'h03, O_WAIT = 8'h01;

   function automatic logic [7:0] outs();
      return {detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy};
   endfunction

   // Reference model: packet phase tracked by name, addr as an int.
   typedef enum int {P_IDLE, P_WAIT, P_FIRST, P_BODY, P_STALL, P_RESUME, P_PAR, P_CHK} phase_t;
   phase_t mp;
   int     maddr;

   function automatic logic [7:0] phase_outs(phase_t p);
      case (p)
         P_IDLE:   return O_DEC;
         P_WAIT:   return O_WAIT;
         P_FIRST:  return O_LFD;
         P_BODY:   return O_LD;
         P_STALL:  return O_FULL;
         P_RESUME: return O_LAF;
         P_PAR:    return O_LP;
         default:  return O_CHK;
      endcase
   endfunction

   task automatic model_clock();
      int din = int'(data_in);
      if (reset) begin mp = P_IDLE; maddr = 0; return; end
      if (mp != P_IDLE && sr[maddr]) begin mp = P_IDLE; return; end
      case (mp)
         P_IDLE:   if (pkt_valid && din < 3) begin
                      maddr = din;
                      mp = emp[din] ? P_FIRST : P_WAIT;
                   end
         P_WAIT:   if (emp[maddr]) mp = P_FIRST;
         P_FIRST:  mp = P_BODY;
         P_BODY:   if (fifo_full) mp = P_STALL; else if (!pkt_valid) mp = P_PAR;
         P_STALL:  if (!fifo_full) mp = P_RESUME;
         P_RESUME: mp = parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_BODY);
         P_PAR:    mp = P_CHK;
         P_CHK:    mp = fifo_full ? P_STALL : P_IDLE;
         default:  mp = P_IDLE;
      endcase
   endtask

   task automatic check(string name, logic [7:0] exp);
      n_cmp++;
      if (outs() !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", name, outs(), exp);
      end
   endtask

   // One clock: inputs already driven; update model at the edge, sample 1 time unit later.
   task automatic tick();
      @(posedge clock);
      model_clock();
      #1;
   endtask

   typedef struct {
      logic       rst, pv, pd, ff, lpv;
      logic [1:0] din;
      logic [2:0] sr, emp;
      logic [7:0] exp;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t v(logic rst, logic pv, logic [1:0] din, logic [2:0] emp_v,
                              logic ff, logic pd, logic lpv, logic [2:0] sr_v, logic [7:0] exp);
      vec_t r;
      r.rst = rst; r.pv = pv; r.din = din; r.emp = emp_v; r.ff = ff;
      r.pd = pd; r.lpv = lpv; r.sr = sr_v; r.exp = exp;
      return r;
   endfunction

   initial begin
      reset = 1'b1; pkt_valid = 1'b0; parity_done = 1'b0; fifo_full = 1'b0;
      low_pkt_valid = 1'b0; data_in = 2'd0; sr = 3'b000; emp = 3'b111;

      //          rst pv din emp    ff pd lpv sr      expected
      tv.push_back(v(1, 0, 0, 3'b111, 0, 0, 0, 3'b000, O_DEC));   // reset
      tv.push_back(v(0, 0, 0, 3'b111, 0, 0, 0, 3'b010, O_DEC));   // soft reset ignored in DECODE
      tv.push_back(v(0, 1, 1, 3'b111, 0, 0, 0, 3'b000, O_LFD));
      tv.push_back(v(0, 1, 1, 3'b111, 0, 0, 0, 3'b000, O_LD));
      tv.push_back(v(0, 1, 1, 3'b111, 0, 0, 0, 3'b000, O_LD));
      tv.push_back(v(0, 0, 1, 3'b111, 0, 0, 0, 3'b000, O_LP));
      tv.push_back(v(0, 0, 0, 3'b111, 0, 0, 0, 3'b000, O_CHK));
      tv.push_back(v(0, 0, 0, 3'b111, 0, 0, 0, 3'b000, O_DEC));
      tv.push_back(v(0, 1, 1, 3'b111, 0, 0, 0, 3'b000, O_LFD));
      tv.push_back(v(0, 1, 1, 3'b111, 0, 0, 0, 3'b000, O_LD));
      tv.push_back(v(0, 1, 1, 3'b111, 1, 0, 0, 3'b000, O_FULL));
      tv.push_back(v(0, 1, 1, 3'b111, 1, 0, 0, 3'b000, O_FULL));
      tv.push_back(v(0, 1, 1, 3'b111, 0, 0, 0, 3'b000, O_LAF));
      tv.push_back(v(0, 0, 1, 3'b111, 0, 0, 1, 3'b000, O_LP));    // low_pkt_valid
      tv.push_back(v(0, 0, 1, 3'b111, 0, 0, 0, 3'b000, O_CHK));
      tv.push_back(v(0, 0, 1, 3'b111, 1, 0, 0, 3'b000, O_FULL));  // full at parity check
      tv.push_back(v(0, 0, 1, 3'b111, 0, 0, 0, 3'b000, O_LAF));
      tv.push_back(v(0, 0, 1, 3'b111, 0, 1, 1, 3'b000, O_DEC));   // parity_done wins
      tv.push_back(v(0, 1, 0, 3'b111, 0, 0, 0, 3'b000, O_LFD));
      tv.push_back(v(0, 1, 0, 3'b111, 0, 0, 0, 3'b000, O_LD));
      tv.push_back(v(0, 1, 0, 3'b111, 1, 0, 0, 3'b000, O_FULL));
      tv.push_back(v(0, 1, 0, 3'b111, 0, 0, 0, 3'b000, O_LAF));
      tv.push_back(v(0, 1, 0, 3'b111, 0, 0, 0, 3'b000, O_LD));    // resume loading
      tv.push_back(v(0, 0, 0, 3'b111, 1, 0, 0, 3'b000, O_FULL));  // fifo_full beats !pkt_valid
      tv.push_back(v(0, 0, 0, 3'b111, 0, 0, 0, 3'b000, O_LAF));
      tv.push_back(v(0, 0, 0, 3'b111, 0, 0, 1, 3'b000, O_LP));
      tv.push_back(v(0, 0, 0, 3'b111, 0, 0, 0, 3'b000, O_CHK));
      tv.push_back(v(0, 0, 0, 3'b111, 0, 0, 0, 3'b000, O_DEC));
      tv.push_back(v(0, 1, 2, 3'b011, 0, 0, 0, 3'b000, O_WAIT));  // port 2 not empty
      tv.push_back(v(0, 0, 0, 3'b011, 0, 0, 0, 3'b000, O_WAIT));
      tv.push_back(v(0, 0, 0, 3'b111, 0, 0, 0, 3'b000, O_LFD));
      tv.push_back(v(0, 1, 2, 3'b111, 0, 0, 0, 3'b000, O_LD));
      tv.push_back(v(0, 1, 2, 3'b111, 0, 0, 0, 3'b001, O_LD));    // other port's soft reset
      tv.push_back(v(0, 1, 2, 3'b111, 0, 0, 0, 3'b100, O_DEC));   // own soft reset
      tv.push_back(v(0, 1, 3, 3'b111, 0, 0, 0, 3'b000, O_DEC));   // invalid address
      tv.push_back(v(0, 1, 1, 3'b111, 0, 0, 0, 3'b000, O_LFD));
      tv.push_back(v(0, 1, 1, 3'b111, 0, 0, 0, 3'b000, O_LD));
      tv.push_back(v(0, 1, 1, 3'b111, 0, 0, 0, 3'b001, O_LD));
      tv.push_back(v(0, 1, 1, 3'b111, 0, 0, 0, 3'b010, O_DEC));
      tv.push_back(v(0, 1, 1, 3'b111, 0, 0, 0, 3'b000, O_LFD));
      tv.push_back(v(0, 1, 1, 3'b111, 0, 0, 0, 3'b000, O_LD));
      tv.push_back(v(1, 1, 1, 3'b111, 1, 0, 0, 3'b010, O_DEC));   // reset mid-packet
      tv.push_back(v(0, 1, 2, 3'b111, 0, 0, 0, 3'b100, O_LFD));   // addr cleared, DECODE ignores sr

      foreach (tv[i]) begin
         reset = tv[i].rst; pkt_valid = tv[i].pv; data_in = tv[i].din; emp = tv[i].emp;
         fifo_full = tv[i].ff; parity_done = tv[i].pd; low_pkt_valid = tv[i].lpv; sr = tv[i].sr;
         tick();
         check($sformatf("vec%0d", i), tv[i].exp);
      end

      // Randomized run against the reference model.
      reset = 1'b1; sr = 3'b000;
      tick();
      check("rand_reset", phase_outs(mp));
      for (int c = 0; c < 3000; c++) begin
         reset         = ($urandom_range(0, 199) == 0);
         pkt_valid     = ($urandom_range(0, 3) != 0);
         data_in       = 2'($urandom_range(0, 3));
         emp           = 3'($urandom);
         fifo_full     = ($urandom_range(0, 3) == 0);
         parity_done   = ($urandom_range(0, 3) == 0);
         low_pkt_valid = ($urandom_range(0, 2) == 0);
         sr            = ($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'b000;
         tick();
         check($sformatf("rand%0d", c), phase_outs(mp));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
